// File: rtl/mio_bus_responder.sv
// MIO bus responder: word RAM plus LED/cycle-counter/status IO window behind a wait-state FSM.
// Access commits WAIT_CYCLES edges after the request is sampled; ready pulses one cycle; stb is ignored while busy.
module mio_bus_responder #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] IO_BASE     = 32'hFFFF_FF00,
    parameter int          LED_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stb,
    input  logic             we,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             ready,
    output logic             err,
    output logic [LED_W-1:0] led
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t      state, state_nxt;
    logic [3:0]  wcnt;
    logic        we_q;
    logic [29:0] waddr_q;
    logic [31:0] wdata_q;
    logic [31:0] cyc;
    logic        last_err;
    logic [31:0] mem [2**ADDR_W];

    logic        commit;
    logic        acc_we;
    logic [29:0] acc_waddr;
    logic [31:0] acc_wdata;
    logic        hit_io;
    logic        hit_ram;
    logic [5:0]  io_off;
    logic [ADDR_W-1:0] ram_idx;
    logic [31:0] io_rd;
    logic        unused_ok;

    assign unused_ok = ^addr[1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (stb) state_nxt = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
            S_WAIT:  if (wcnt <= 4'd1) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ready  = (state == S_ACK);
    // With zero wait states the commit edge is the sampling edge, so the live bus is used directly.
    assign commit = reset && (state_nxt == S_ACK) && (state != S_ACK);

    always_comb begin
        acc_we    = we_q;
        acc_waddr = waddr_q;
        acc_wdata = wdata_q;
        if (state == S_IDLE) begin
            acc_we    = we;
            acc_waddr = addr[31:2];
            acc_wdata = wdata;
        end
    end

    assign hit_io  = (acc_waddr[29:6] == IO_BASE[31:8]);
    assign hit_ram = !hit_io && (acc_waddr[29:ADDR_W] == '0);
    assign io_off  = acc_waddr[5:0];
    assign ram_idx = acc_waddr[ADDR_W-1:0];

    always_comb begin
        io_rd = 32'h0;
        case (io_off)
            6'd0:    io_rd = 32'(led);
            6'd1:    io_rd = cyc;
            6'd2:    io_rd = {31'b0, last_err};
            default: io_rd = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wcnt     <= 4'd0;
            we_q     <= 1'b0;
            waddr_q  <= 30'd0;
            wdata_q  <= 32'd0;
            rdata    <= 32'd0;
            err      <= 1'b0;
            led      <= '0;
            cyc      <= 32'd0;
            last_err <= 1'b0;
        end else begin
            state <= state_nxt;
            cyc   <= cyc + 32'd1;
            err   <= 1'b0;
            if (state == S_IDLE && stb) begin
                wcnt    <= WAIT_LD;
                we_q    <= we;
                waddr_q <= addr[31:2];
                wdata_q <= wdata;
            end else if (state == S_WAIT) begin
                wcnt <= wcnt - 4'd1;
            end
            if (commit) begin
                if (hit_io) begin
                    if (acc_we) begin
                        if (io_off == 6'd0) led <= acc_wdata[LED_W-1:0];
                    end else begin
                        rdata <= io_rd;
                        if (io_off == 6'd2) last_err <= 1'b0;
                    end
                end else if (hit_ram) begin
                    if (!acc_we) rdata <= mem[ram_idx];
                end else begin
                    err      <= 1'b1;
                    last_err <= 1'b1;
                    if (!acc_we) rdata <= 32'h0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && hit_ram && acc_we) mem[ram_idx] <= acc_wdata;
    end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Randomized bench for mio_bus_responder against a transaction-level memory/IO model.
module tb_mio_bus_responder;

    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    logic [31:0] rdata2, rdata0;
    logic        ready2, ready0, err2, err0;
    logic [7:0]  led2, led0;

    mio_bus_responder #(.WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .stb(stb), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata2), .ready(ready2), .err(err2), .led(led2)
    );

    mio_bus_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .stb(stb), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .ready(ready0), .err(err0), .led(led0)
    );

    always #5 clk = ~clk;

    bit use0 = 1'b0;
    logic [31:0] cur_rdata;
    logic        cur_ready, cur_err;
    assign cur_rdata = use0 ? rdata0 : rdata2;
    assign cur_ready = use0 ? ready0 : ready2;
    assign cur_err   = use0 ? err0   : err2;

    // Reference cycle count: clocks elapsed since reset release.
    logic [31:0] tb_cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_cyc <= 32'd0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    int checks = 0;
    int passes = 0;

    logic [31:0] mem_m [1024];
    logic [7:0]  led_m = 8'h0;
    logic        last_err_m = 1'b0;
    logic [31:0] rdata_m = 32'h0;

    int          r_lat;
    logic [31:0] r_rd, e_rd;
    logic        r_err, e_err;

    task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic e,
                       output logic [31:0] cyc_at);
        @(posedge clk); #1;
        stb = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        stb = 1'b0;
        lat = 1;
        while (!cur_ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = cur_rdata;
        e = cur_err;
        cyc_at = tb_cyc - 32'd1;
    endtask

    task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] cyc_at, output logic [31:0] rd, output logic e);
        logic [31:0] word;
        logic [7:0]  off;
        word = a >> 2;
        off  = a[7:0] & 8'hFC;
        e = 1'b0;
        if (a[31:8] == 24'hFFFFFF) begin
            if (w) begin
                if (off == 8'h00) led_m = d[7:0];
            end else begin
                case (off)
                    8'h00:   rdata_m = {24'h0, led_m};
                    8'h04:   rdata_m = cyc_at;
                    8'h08: begin rdata_m = {31'h0, last_err_m}; last_err_m = 1'b0; end
                    default: rdata_m = 32'h0;
                endcase
            end
        end else if (word < 32'd1024) begin
            if (w) mem_m[word] = d;
            else   rdata_m = mem_m[word];
        end else begin
            e = 1'b1;
            last_err_m = 1'b1;
            if (!w) rdata_m = 32'h0;
        end
        rd = rdata_m;
    endtask

    task automatic run(input bit w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] c;
        txn(w, a, d, r_lat, r_rd, r_err, c);
        model(w, a, d, c, e_rd, e_err);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        stb = 1'b0;
        reset = 1'b0;
        led_m = 8'h0; last_err_m = 1'b0; rdata_m = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk); #1;
        checks++; if (rdata2 !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", rdata2); else passes++;
        checks++; if (ready2 !== 1'b0)  $display("FAIL reset_ready got=%b exp=0", ready2); else passes++;
        checks++; if (led2 !== 8'h0)    $display("FAIL reset_led got=%h exp=0", led2); else passes++;
        checks++; if (err2 !== 1'b0)    $display("FAIL reset_err got=%b exp=0", err2); else passes++;
    endtask

    task automatic test_counter();
        logic [31:0] v1;
        run(1'b0, 32'hFFFF_FF04, 32'h0);
        v1 = r_rd;
        checks++; if (r_rd !== e_rd) $display("FAIL cnt_abs got=%h exp=%h", r_rd, e_rd); else passes++;
        @(posedge clk);
        run(1'b0, 32'hFFFF_FF04, 32'h0);
        checks++; if (r_rd - v1 !== 32'(WC + 3)) $display("FAIL cnt_delta got=%0d exp=%0d", r_rd - v1, WC + 3); else passes++;
    endtask

    task automatic test_ram();
        run(1'b1, 32'h0000_0010, 32'hCAFE_BABE);
        checks++; if (r_lat !== WC + 1) $display("FAIL ram_wr_latency got=%0d exp=%0d", r_lat, WC + 1); else passes++;
        checks++; if (r_rd !== e_rd) $display("FAIL ram_wr_keeps_rdata got=%h exp=%h", r_rd, e_rd); else passes++;
        run(1'b0, 32'h0000_0010, 32'h0);
        checks++; if (r_rd !== 32'hCAFE_BABE) $display("FAIL ram_rd got=%h exp=cafebabe", r_rd); else passes++;
        checks++; if (r_lat !== WC + 1) $display("FAIL ram_rd_latency got=%0d exp=%0d", r_lat, WC + 1); else passes++;
        run(1'b0, 32'h0000_0013, 32'h0);
        checks++; if (r_rd !== e_rd) $display("FAIL ram_alias got=%h exp=%h", r_rd, e_rd); else passes++;
    endtask

    task automatic test_led();
        run(1'b1, 32'hFFFF_FF00, 32'h1234_56A5);
        checks++; if (led2 !== 8'hA5) $display("FAIL led_ack got=%h exp=a5", led2); else passes++;
        run(1'b0, 32'hFFFF_FF00, 32'h0);
        checks++; if (r_rd !== 32'h0000_00A5) $display("FAIL led_rd got=%h exp=000000a5", r_rd); else passes++;
    endtask

    task automatic test_unmapped();
        run(1'b1, 32'h0000_0000, 32'h5A5A_0001);
        checks++; if (r_err !== 1'b0) $display("FAIL ram_no_err got=%b exp=0", r_err); else passes++;
        run(1'b1, 32'h0001_0000, 32'hDEAD_BEEF);
        checks++; if (r_err !== 1'b1) $display("FAIL unmapped_err got=%b exp=1", r_err); else passes++;
        run(1'b0, 32'h0000_0000, 32'h0);
        checks++; if (r_rd !== e_rd) $display("FAIL unmapped_no_write got=%h exp=%h", r_rd, e_rd); else passes++;
        run(1'b0, 32'hFFFF_FF08, 32'h0);
        checks++; if (r_rd !== 32'h1) $display("FAIL status_set got=%h exp=1", r_rd); else passes++;
        run(1'b0, 32'hFFFF_FF08, 32'h0);
        checks++; if (r_rd !== 32'h0) $display("FAIL status_clr got=%h exp=0", r_rd); else passes++;
    endtask

    task automatic test_back_to_back();
        int last_rdy, n_rdy, bad_gap, bad_data, cyc;
        logic [31:0] exp_v, dummy_e;
        logic        dummy_err;
        run(1'b1, 32'h0000_0000, 32'h0BAD_F00D);
        run(1'b1, 32'h0000_0004, 32'h600D_CAFE);
        @(posedge clk); #1;
        stb = 1'b1; we = 1'b0; addr = 32'h0;
        last_rdy = -1; n_rdy = 0; bad_gap = 0; bad_data = 0; cyc = 0;
        while (n_rdy < 4 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (ready2) begin
                model(1'b0, addr, 32'h0, 32'h0, exp_v, dummy_err);
                if (rdata2 !== exp_v) bad_data++;
                if (last_rdy >= 0 && cyc - last_rdy != WC + 2) bad_gap++;
                last_rdy = cyc;
                n_rdy++;
                addr = addr ^ 32'h4;
                if (n_rdy == 4) stb = 1'b0;
            end
        end
        dummy_e = exp_v;
        checks++; if (n_rdy !== 4) $display("FAIL b2b_count got=%0d exp=4", n_rdy); else passes++;
        checks++; if (bad_gap !== 0) $display("FAIL b2b_period bad=%0d exp=0 (period %0d)", bad_gap, WC + 2); else passes++;
        checks++; if (bad_data !== 0) $display("FAIL b2b_data bad=%0d exp=0 last=%h", bad_data, dummy_e); else passes++;
    endtask

    task automatic test_random();
        int bad_lat, bad_rd, bad_err;
        logic [31:0] a, d;
        bit w;
        for (int i = 0; i < 32; i++) run(1'b1, 32'(i * 4), $urandom);
        bad_lat = 0; bad_rd = 0; bad_err = 0;
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            case ($urandom_range(0, 5))
                0:       a = 32'($urandom_range(0, 31) * 4) | 32'($urandom_range(0, 3));
                1:       a = 32'hFFFF_FF00;
                2:       a = 32'hFFFF_FF04;
                3:       a = 32'hFFFF_FF08;
                4:       a = 32'hFFFF_FF00 | 32'($urandom_range(3, 63) * 4);
                default: a = 32'h0001_0000 | ($urandom & 32'h7FFE_FFFF);
            endcase
            run(w, a, d);
            if (r_lat != WC + 1) bad_lat++;
            if (r_rd !== e_rd) begin
                bad_rd++;
                $display("FAIL rand_rdata a=%h we=%b got=%h exp=%h", a, w, r_rd, e_rd);
            end
            if (r_err !== e_err) bad_err++;
            checks++; if (led2 !== led_m) $display("FAIL rand_led a=%h got=%h exp=%h", a, led2, led_m); else passes++;
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        checks++; if (bad_lat !== 0) $display("FAIL rand_latency bad=%0d exp=0", bad_lat); else passes++;
        checks++; if (bad_rd !== 0)  $display("FAIL rand_rdata_total bad=%0d exp=0", bad_rd); else passes++;
        checks++; if (bad_err !== 0) $display("FAIL rand_err bad=%0d exp=0", bad_err); else passes++;
    endtask

    task automatic test_reset_mid();
        int n_rdy;
        run(1'b1, 32'h0000_0020, 32'h1111_2222);
        @(posedge clk); #1;
        stb = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        stb = 1'b0;
        reset = 1'b0;
        led_m = 8'h0; last_err_m = 1'b0; rdata_m = 32'h0;
        n_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ready2) n_rdy++;
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ready2) n_rdy++;
        end
        checks++; if (n_rdy !== 0) $display("FAIL rst_mid_ready got=%0d exp=0", n_rdy); else passes++;
        run(1'b0, 32'h0000_0020, 32'h0);
        checks++; if (r_rd !== 32'h1111_2222) $display("FAIL rst_mid_data got=%h exp=11112222", r_rd); else passes++;
    endtask

    task automatic test_wait0();
        logic [31:0] d;
        use0 = 1'b1;
        do_reset();
        d = $urandom;
        run(1'b1, 32'h0000_0040, d);
        checks++; if (r_lat !== 1) $display("FAIL w0_wr_latency got=%0d exp=1", r_lat); else passes++;
        @(posedge clk); #1;
        checks++; if (ready0 !== 1'b0) $display("FAIL w0_ready_pulse got=%b exp=0", ready0); else passes++;
        run(1'b0, 32'h0000_0040, 32'h0);
        checks++; if (r_lat !== 1) $display("FAIL w0_rd_latency got=%0d exp=1", r_lat); else passes++;
        checks++; if (r_rd !== d) $display("FAIL w0_rd got=%h exp=%h", r_rd, d); else passes++;
        run(1'b1, 32'h0002_0000, 32'h0);
        checks++; if (r_err !== 1'b1) $display("FAIL w0_err got=%b exp=1", r_err); else passes++;
        use0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_counter();
        test_ram();
        test_led();
        test_unmapped();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_wait0();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mio_bus_responder.md
Name: mio_bus_responder

Overview:
- Memory/IO-side responder for the multi-cycle CPU's MIO bus.
- Accepts the CPU's strobe, write-enable, address and write data. Returns read data plus a one-cycle ready pulse after a programmable number of wait states.
- Backs a word-addressed on-chip RAM and a small IO register window: LED register, free-running cycle counter, status.
- Sits between the CPU and memory in the top level. It drives the CPU's data_in/MIO_ready from the CPU's Addr_out/data_out/mem_w/cpu_stb_o.

Parameters:
- ADDR_W, 10, RAM word-address width (RAM depth = 2^ADDR_W 32-bit words).
- WAIT_CYCLES, 2, wait states inserted before ready (0..15 legal).
- IO_BASE, 32'hFFFF_FF00, base of the 256-byte IO window (low 8 bits ignored).
- LED_W, 8, width of the LED output register.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- stb  in  1  request strobe from CPU (cpu_stb_o)
- we  in  1  1 = write, 0 = read (mem_w)
- addr  in  32  byte address (Addr_out); addr[1:0] ignored
- wdata  in  32  write data (data_out)
- rdata  out  32  read data to CPU (data_in)
- ready  out  1  one-cycle completion pulse (MIO_ready)
- err  out  1  pulses with ready when the address was unmapped
- led  out  LED_W  LED register contents

Behaviour:
- Reset (reset=0, async):
  - State IDLE; rdata=0, ready=0, err=0, led=0, cycle counter=0, last_err=0.
  - RAM contents are not cleared.
  - Reset mid-transaction aborts it: no write, no ready.
- FSM states and transitions:
  - IDLE: stb=1 at a clock edge (sampling edge, call it E0) latches addr, we, wdata. Wait counter loads WAIT_CYCLES. Next state is WAIT, or ACK if WAIT_CYCLES=0.
  - WAIT: counter decrements each edge. When the counter reaches 0, the FSM moves to ACK on that edge.
  - ACK: ready=1 for exactly one cycle, then IDLE unconditionally.
- Latency: ready is high during the cycle following edge E0+WAIT_CYCLES. Minimum request-to-request period is WAIT_CYCLES+2 cycles.
- Commit point: the access happens on the edge that enters ACK, using the latched values.
  - Write: RAM or register updated on that edge.
  - Read: rdata loaded on that edge.
- rdata holds its value until the next read completes. Write transactions leave rdata unchanged.
- stb is ignored outside IDLE; dropping stb mid-transaction does not cancel the access.
- In the IDLE cycle after ACK, a still-high stb is sampled as a new request.
- Address decode, in priority order:
  - IO window (addr[31:8]==IO_BASE[31:8]), selected by offset addr[7:2]:
    - 0x00: LED register, R/W. Writes take wdata[LED_W-1:0]; reads return it zero-extended.
    - 0x04: cycle counter, RO, 32-bit, increments every clock, wraps 0xFFFFFFFF→0. Writes are ignored.
    - 0x08: status, RO = {31'b0, last_err}. A read of status clears last_err.
    - Other IO offsets: reads return 0, writes are ignored, err stays 0.
  - RAM: addr[31:2] < 2^ADDR_W; RAM index = addr[ADDR_W+1:2].
  - Otherwise unmapped: reads return 32'h0, writes are dropped. err=1 in the ACK cycle, and last_err is set to 1.
- Simultaneous events:
  - A status read and an unmapped access cannot overlap, since there is one transaction at a time.
  - The counter wraps silently.

Test Plan:
- Reset → first cycle after reset release: rdata=0, ready=0, led=0.
  - Release reset, then read 0xFFFFFF04 twice with 1 idle cycle between. Values differ by exactly WAIT_CYCLES+3.
- WAIT_CYCLES=2, write 0x0000_0010 ← 0xCAFEBABE, then read it back.
  - ready is high exactly in the 3rd cycle after the sampling edge; rdata=0xCAFEBABE on the read ready.
  - addr 0x0000_0013 aliases the same word.
- Write 0xFFFFFF00 ← 0x1234_56A5 → led=0xA5 from the ACK cycle. A read of 0xFFFFFF00 returns 0x0000_00A5.
- Write 0x0001_0000 (beyond 1024 words) → err=1 with ready, no RAM word changes.
  - Read 0xFFFFFF08 returns 1; a second read of it returns 0.
- Hold stb=1 continuously across reads of 0x0 and 0x4. Each ready is followed by exactly one IDLE cycle with ready=0.
  - Drop stb one cycle after the sampling edge → the transaction still completes with ready.
- Assert reset during WAIT of a write to 0x20 ← 0xFFFFFFFF → no ready. After reset, a read of 0x20 returns the pre-reset value.
  - Rerun with WAIT_CYCLES=0: ready follows the sampling edge immediately.
